// File: rtl/sdram_port_responder.sv
// sdram_port_responder: toggle-handshake request port bridged onto a valid/ready SDRAM command channel.
// Define SDRAM_PORT_RESPONDER_MERGE_EN to build in the low-byte write merge buffer (flush is ignored otherwise).
module sdram_port_responder #(
   parameter int unsigned AW = 23
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          port_req,
   input  logic [AW-1:0] port_a,
   input  logic [1:0]    port_ds,
   input  logic          port_we,
   input  logic [15:0]   port_d,
   output logic          port_ack,
   output logic [15:0]   port_q,
   input  logic          flush,
   output logic          mem_valid,
   input  logic          mem_ready,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [1:0]    mem_be,
   output logic [15:0]   mem_wdata,
   input  logic          mem_rvalid,
   input  logic [15:0]   mem_rdata
);

   typedef enum logic [1:0] {IDLE, ISSUE, RWAIT, ACK} state_t;

   state_t state;
   logic   req_l;
   logic   we_l;
   logic   pending;

   always_comb begin
      pending = (port_req != port_ack);
   end

`ifdef SDRAM_PORT_RESPONDER_MERGE_EN
   logic          mb_full;
   logic [AW-1:0] mb_addr;
   logic [7:0]    mb_byte;
   logic          flush_pend;
   logic          draining;
   logic          flush_now;
   logic          merge_hit;

   always_comb begin
      flush_now = flush || flush_pend;
      merge_hit = mb_full && port_we && (port_ds == 2'b10) && (port_a == mb_addr);
   end
`else
   logic unused_flush;

   always_comb begin
      unused_flush = flush;
   end
`endif

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state     <= IDLE;
         req_l     <= 1'b0;
         we_l      <= 1'b0;
         port_ack  <= 1'b0;
         port_q    <= '0;
         mem_valid <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_be    <= '0;
         mem_wdata <= '0;
`ifdef SDRAM_PORT_RESPONDER_MERGE_EN
         mb_full    <= 1'b0;
         mb_addr    <= '0;
         mb_byte    <= '0;
         flush_pend <= 1'b0;
         draining   <= 1'b0;
`endif
      end else begin
`ifdef SDRAM_PORT_RESPONDER_MERGE_EN
         if (flush && (state != IDLE)) begin
            flush_pend <= 1'b1;
         end
`endif
         case (state)
            IDLE: begin
`ifdef SDRAM_PORT_RESPONDER_MERGE_EN
               flush_pend <= 1'b0;
               // A buffered byte is drained without consuming the request; IDLE then sees it again.
               if (mb_full && (flush_now || (pending && !merge_hit))) begin
                  mb_full   <= 1'b0;
                  draining  <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= mb_addr;
                  mem_be    <= 2'b01;
                  mem_wdata <= {8'h00, mb_byte};
                  mem_valid <= 1'b1;
                  state     <= ISSUE;
               end else if (pending && merge_hit) begin
                  req_l     <= port_req;
                  we_l      <= 1'b1;
                  mb_full   <= 1'b0;
                  mem_we    <= 1'b1;
                  mem_addr  <= port_a;
                  mem_be    <= 2'b11;
                  mem_wdata <= {port_d[15:8], mb_byte};
                  mem_valid <= 1'b1;
                  state     <= ISSUE;
               end else if (pending && port_we && (port_ds == 2'b01)) begin
                  req_l   <= port_req;
                  we_l    <= 1'b1;
                  mb_full <= 1'b1;
                  mb_addr <= port_a;
                  mb_byte <= port_d[7:0];
                  state   <= ACK;
               end else
`endif
               if (pending) begin
                  req_l     <= port_req;
                  we_l      <= port_we;
                  mem_we    <= port_we;
                  mem_addr  <= port_a;
                  mem_be    <= port_ds;
                  mem_wdata <= port_d;
                  if (port_ds == 2'b00) begin
                     state <= ACK;
                  end else begin
                     mem_valid <= 1'b1;
                     state     <= ISSUE;
                  end
               end
            end

            ISSUE: begin
               if (mem_ready) begin
                  mem_valid <= 1'b0;
`ifdef SDRAM_PORT_RESPONDER_MERGE_EN
                  draining <= 1'b0;
                  if (draining) state <= IDLE;
                  else
`endif
                  state <= we_l ? ACK : RWAIT;
               end
            end

            RWAIT: begin
               if (mem_rvalid) begin
                  port_q <= mem_rdata;
                  state  <= ACK;
               end
            end

            ACK: begin
               port_ack <= req_l;
               state    <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sdram_port_responder.sv
// Scoreboard bench for sdram_port_responder: word-memory reference model, random and directed requests.
module tb_sdram_port_responder;

   localparam int AW = 23;

   logic          clk_sys = 1'b0;
   logic          reset = 1'b1;
   logic          port_req = 1'b0;
   logic [AW-1:0] port_a = '0;
   logic [1:0]    port_ds = '0;
   logic          port_we = 1'b0;
   logic [15:0]   port_d = '0;
   logic          port_ack;
   logic [15:0]   port_q;
   logic          flush = 1'b0;
   logic          mem_valid;
   logic          mem_ready = 1'b0;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [1:0]    mem_be;
   logic [15:0]   mem_wdata;
   logic          mem_rvalid = 1'b0;
   logic [15:0]   mem_rdata = '0;

   sdram_port_responder #(.AW(AW)) dut (
      .clk_sys(clk_sys), .reset(reset), .port_req(port_req), .port_a(port_a),
      .port_ds(port_ds), .port_we(port_we), .port_d(port_d), .port_ack(port_ack),
      .port_q(port_q), .flush(flush), .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk_sys = ~clk_sys;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [1:0]    be;
      logic [15:0]   wdata;
   } cmd_t;

   typedef struct {
      logic        has_cmd;
      logic        we;
      logic [15:0] q;
   } rsp_t;

   cmd_t exp_cmd[$];
   rsp_t exp_rsp[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   last_hs_cyc = -100;
   int   valid_cycles = 0;
   int   ready_mode = 0;
   int   rd_fixed = -1;
   int   stall_seen = 0;

   logic [15:0] model_mem [logic [AW-1:0]];
   logic [15:0] resp_mem  [logic [AW-1:0]];
   logic [15:0] model_q = '0;

   function automatic logic [15:0] dflt(input logic [AW-1:0] a);
      return a[15:0] ^ 16'hA5C3;
   endfunction

   function automatic logic [15:0] model_read(input logic [AW-1:0] a);
      return model_mem.exists(a) ? model_mem[a] : dflt(a);
   endfunction

   function automatic logic [15:0] resp_read(input logic [AW-1:0] a);
      return resp_mem.exists(a) ? resp_mem[a] : dflt(a);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic model_write(input logic [AW-1:0] a, input logic [1:0] ds, input logic [15:0] d);
      logic [15:0] w;
      w = model_read(a);
      if (ds[0]) w[7:0] = d[7:0];
      if (ds[1]) w[15:8] = d[15:8];
      model_mem[a] = w;
   endtask

   task automatic push_cmd(input logic we, input logic [AW-1:0] a, input logic [1:0] be, input logic [15:0] d);
      cmd_t c;
      c.we = we; c.addr = a; c.be = be; c.wdata = d;
      exp_cmd.push_back(c);
   endtask

   task automatic push_rsp(input logic has_cmd, input logic we);
      rsp_t r;
      r.has_cmd = has_cmd; r.we = we; r.q = model_q;
      exp_rsp.push_back(r);
   endtask

   // Plain (unmerged) request semantics: one command per non-empty strobe, reads return the whole word.
   task automatic push_req(input logic [AW-1:0] a, input logic [1:0] ds, input logic we, input logic [15:0] d);
      if (ds != 2'b00) begin
         push_cmd(we, a, ds, d);
         if (we) model_write(a, ds, d);
         else model_q = model_read(a);
      end
      push_rsp(ds != 2'b00, we);
   endtask

   task automatic drive(input logic [AW-1:0] a, input logic [1:0] ds, input logic we, input logic [15:0] d);
      port_a = a; port_ds = ds; port_we = we; port_d = d;
      port_req = ~port_req;
   endtask

   task automatic issue(input logic [AW-1:0] a, input logic [1:0] ds, input logic we, input logic [15:0] d);
      push_req(a, ds, we, d);
      drive(a, ds, we, d);
   endtask

   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      while ((exp_rsp.size() != 0 || exp_cmd.size() != 0) && n < budget) begin
         @(posedge clk_sys);
         n++;
      end
      if (exp_rsp.size() != 0 || exp_cmd.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL timeout pending_rsp=%0d pending_cmd=%0d required=0", exp_rsp.size(), exp_cmd.size());
         exp_rsp.delete();
         exp_cmd.delete();
      end
      #1;
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   // Downstream memory: random ready, delayed read return from its own word store.
   initial begin
      logic          hs;
      logic          h_we;
      logic [AW-1:0] h_a;
      logic [1:0]    h_be;
      logic [15:0]   h_d;
      logic [15:0]   w;
      logic          rd_active;
      logic [AW-1:0] rd_addr;
      int            rd_cnt;
      rd_active = 1'b0; rd_addr = '0; rd_cnt = 0;
      forever begin
         @(negedge clk_sys);
         hs = mem_valid && mem_ready && !reset;
         h_we = mem_we; h_a = mem_addr; h_be = mem_be; h_d = mem_wdata;
         if (mem_valid && !mem_ready && !reset) stall_seen++;
         @(posedge clk_sys);
         #1;
         mem_rvalid = 1'b0;
         mem_rdata = 16'($urandom);
         if (hs) begin
            if (h_we) begin
               w = resp_read(h_a);
               if (h_be[0]) w[7:0] = h_d[7:0];
               if (h_be[1]) w[15:8] = h_d[15:8];
               resp_mem[h_a] = w;
            end else begin
               rd_active = 1'b1;
               rd_addr = h_a;
               rd_cnt = (rd_fixed >= 0) ? rd_fixed : int'($urandom_range(0, 4));
            end
         end
         if (rd_active) begin
            if (rd_cnt == 0) begin
               mem_rvalid = 1'b1;
               mem_rdata = resp_read(rd_addr);
               rd_active = 1'b0;
            end else begin
               rd_cnt--;
            end
         end
         case (ready_mode)
            1: mem_ready = 1'b1;
            2: mem_ready = (stall_seen >= 5);
            default: mem_ready = ($urandom_range(0, 3) != 0);
         endcase
      end
   end

   // Monitor: pops expected commands on handshakes and expected responses on acknowledge toggles.
   initial begin
      logic          prev_stall;
      logic          prev_ack;
      cmd_t          pc;
      cmd_t          c;
      rsp_t          r;
      prev_stall = 1'b0;
      prev_ack = 1'b0;
      pc.we = 1'b0; pc.addr = '0; pc.be = '0; pc.wdata = '0;
      forever begin
         @(negedge clk_sys);
         cyc++;
         if (reset) begin
            prev_stall = 1'b0;
            prev_ack = port_ack;
            continue;
         end
         if (mem_valid) valid_cycles++;
         if (prev_stall) begin
            check("stall_hold", {12'h0, mem_valid, mem_we, mem_be, mem_wdata},
                  {12'h0, 1'b1, pc.we, pc.be, pc.wdata});
            check("stall_addr", 32'(mem_addr), 32'(pc.addr));
         end
         prev_stall = mem_valid && !mem_ready;
         pc.we = mem_we; pc.addr = mem_addr; pc.be = mem_be; pc.wdata = mem_wdata;
         if (mem_valid && mem_ready) begin
            if (exp_cmd.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_cmd actual=addr %0h be %0h required=none", mem_addr, mem_be);
            end else begin
               c = exp_cmd.pop_front();
               check("cmd_we", 32'(mem_we), 32'(c.we));
               check("cmd_addr", 32'(mem_addr), 32'(c.addr));
               check("cmd_be", 32'(mem_be), 32'(c.be));
               check("cmd_wdata", 32'(mem_wdata), 32'(c.wdata));
            end
            last_hs_cyc = cyc;
         end
         if (port_ack != prev_ack) begin
            prev_ack = port_ack;
            if (exp_rsp.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ack actual=%0b required=no_toggle", port_ack);
            end else begin
               r = exp_rsp.pop_front();
               check("ack_q", 32'(port_q), 32'(r.q));
               if (r.has_cmd && r.we) check("wr_ack_latency", 32'(cyc - last_hs_cyc), 32'd2);
            end
         end
      end
   end

   initial begin
      logic [AW-1:0] ra;
      logic [1:0]    rds;
      logic          rwe;
      logic [15:0]   rdat;
      int            n;

      cycles(3);
      reset = 1'b0;
      @(negedge clk_sys);
      check("rst_ack", 32'(port_ack), 32'd0);
      check("rst_q", 32'(port_q), 32'd0);
      check("rst_valid", 32'(mem_valid), 32'd0);
      check("rst_we", 32'(mem_we), 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_be", 32'(mem_be), 32'd0);
      check("rst_wdata", 32'(mem_wdata), 32'd0);
      @(posedge clk_sys);
      #1;

      // Full-word write with the channel always ready.
      ready_mode = 1;
      valid_cycles = 0;
      issue(23'h100, 2'b11, 1'b1, 16'hBEEF);
      wait_idle(50);
      check("single_valid", 32'(valid_cycles), 32'd1);

      // Read returned a few cycles after the handshake.
      model_mem[23'h4000] = 16'h1234;
      resp_mem[23'h4000] = 16'h1234;
      rd_fixed = 3;
      issue(23'h4000, 2'b11, 1'b0, 16'h0);
      wait_idle(50);
      check("read_4000", 32'(port_q), 32'h1234);
      rd_fixed = -1;

      // Stalled write: ready low for the first five valid cycles.
      ready_mode = 2;
      stall_seen = 0;
      valid_cycles = 0;
      issue(23'h55, 2'b11, 1'b1, 16'hC0DE);
      wait_idle(50);
      check("stall_valid_cycles", 32'(valid_cycles), 32'd6);

      // Second toggle while the first request is in flight.
      ready_mode = 0;
      issue(23'h3, 2'b11, 1'b1, 16'h1111);
      @(posedge clk_sys);
      #1;
      issue(23'h3, 2'b10, 1'b0, 16'h0);
      wait_idle(200);

      for (int i = 0; i < 60; i++) begin
         ra = ($urandom_range(0, 9) == 0) ? 23'h4000 : AW'($urandom_range(0, 15));
         rds = 2'($urandom_range(0, 3));
         rwe = 1'($urandom_range(0, 1));
         rdat = 16'($urandom);
`ifdef SDRAM_PORT_RESPONDER_MERGE_EN
         if (rwe && rds == 2'b01) rds = 2'b11;
`endif
         issue(ra, rds, rwe, rdat);
         wait_idle(300);
      end

      // Reset while waiting for read data; the late return must be ignored.
      ready_mode = 1;
      rd_fixed = 6;
      issue(23'h7, 2'b11, 1'b0, 16'h0);
      n = 0;
      while (exp_cmd.size() != 0 && n < 50) begin
         @(posedge clk_sys);
         n++;
      end
      #1;
      check("abandon_handshake_seen", 32'(exp_cmd.size()), 32'd0);
      reset = 1'b1;
      port_req = 1'b0;
      exp_rsp.delete();
      exp_cmd.delete();
      model_q = '0;
      cycles(2);
      reset = 1'b0;
      cycles(12);
      check("abandon_ack", 32'(port_ack), 32'd0);
      check("abandon_q", 32'(port_q), 32'd0);
      rd_fixed = -1;

      // A request already pending as reset releases.
      reset = 1'b1;
      port_a = 23'h9; port_ds = 2'b11; port_we = 1'b1; port_d = 16'h7E57;
      port_req = 1'b1;
      push_req(23'h9, 2'b11, 1'b1, 16'h7E57);
      cycles(2);
      reset = 1'b0;
      wait_idle(50);
      check("post_reset_req_ack", 32'(port_ack), 32'd1);

`ifdef SDRAM_PORT_RESPONDER_MERGE_EN
      ready_mode = 1;
      // Low byte buffered, high byte to the same word merges into one command.
      drive(23'h20, 2'b01, 1'b1, 16'h00AA);
      model_write(23'h20, 2'b01, 16'h00AA);
      push_rsp(1'b0, 1'b1);
      wait_idle(50);
      drive(23'h20, 2'b10, 1'b1, 16'hBB00);
      model_write(23'h20, 2'b10, 16'hBB00);
      push_cmd(1'b1, 23'h20, 2'b11, 16'hBBAA);
      push_rsp(1'b1, 1'b1);
      wait_idle(50);
      // Buffered byte is drained before an unrelated write.
      drive(23'h20, 2'b01, 1'b1, 16'h0011);
      model_write(23'h20, 2'b01, 16'h0011);
      push_rsp(1'b0, 1'b1);
      wait_idle(50);
      push_cmd(1'b1, 23'h20, 2'b01, 16'h0011);
      issue(23'h21, 2'b11, 1'b1, 16'h5566);
      wait_idle(50);
      // Flush forces out a lone buffered byte.
      drive(23'h30, 2'b01, 1'b1, 16'h0077);
      model_write(23'h30, 2'b01, 16'h0077);
      push_rsp(1'b0, 1'b1);
      wait_idle(50);
      push_cmd(1'b1, 23'h30, 2'b01, 16'h0077);
      flush = 1'b1;
      cycles(1);
      flush = 1'b0;
      wait_idle(50);
      issue(23'h20, 2'b11, 1'b0, 16'h0);
      wait_idle(50);
`endif

      cycles(5);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
